buffer_mc: RTL and testbench

- Multi-channel successor to the single-channel AA buffer wrapper.
- Holds N_CHANS independent circular FIFOs in one block, accepts channel-tagged writes and drains them round-robin onto one output stream.
- Output uses a valid/ready handshake; write overflows are reported in-band as error words.
- Sits between channelised producers (e.g. channelizer outputs) and a single shared downstream consumer.

---
 rtl/buffer_mc.sv | 190 +++++++++++++++++++
 tb/tb_buffer_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_mc.sv
// buffer_mc: N_CHANS independent circular FIFOs sharing one output stream.
//
// Writes carry a channel tag and are accepted one per cycle. A write to a full
// channel is dropped and leaves a pending error for that channel; pending
// errors are reported in-band ahead of data as WRITEERRORCODE words. Data is
// drained round-robin over the non-empty channels into a single output register.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_data/in_chan   write word and its target channel
//   in_nd             write strobe
//   flush[N_CHANS]    per-channel synchronous clear (wins over same-cycle write/pop)
//   out_ready         consumer accepts the current output word
//   out_data/out_chan output word and its source channel
//   out_err           output word is an overflow error code
//   out_nd            output word valid
//   full/afull        registered per-channel count == BUFFER_LENGTH / >= AFULL_THRESH
//
// Output handshake: a word transfers on a rising edge where out_nd=1 and
// out_ready=1. While out_nd=1 and out_ready=0 all out_* hold stable. out_nd
// never depends on out_ready, and the output register reloads whenever it is
// empty or being consumed in the same cycle.
module buffer_mc #(
  parameter int WDTH              = 32,
  parameter int N_CHANS           = 4,
  parameter int LOG_N_CHANS       = 2,
  parameter int BUFFER_LENGTH     = 16,
  parameter int LOG_BUFFER_LENGTH = 4,
  parameter int AFULL_THRESH      = 12,
  parameter logic [WDTH-1:0] WRITEERRORCODE = {WDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WDTH-1:0]        in_data,
  input  logic [LOG_N_CHANS-1:0] in_chan,
  input  logic                   in_nd,
  input  logic [N_CHANS-1:0]     flush,
  input  logic                   out_ready,
  output logic [WDTH-1:0]        out_data,
  output logic [LOG_N_CHANS-1:0] out_chan,
  output logic                   out_err,
  output logic                   out_nd,
  output logic [N_CHANS-1:0]     full,
  output logic [N_CHANS-1:0]     afull
);

  localparam logic [LOG_BUFFER_LENGTH:0]   FULL_CNT = BUFFER_LENGTH;
  localparam logic [LOG_BUFFER_LENGTH:0]   AF_CNT   = AFULL_THRESH;
  localparam logic [LOG_BUFFER_LENGTH:0]   CNT_ONE  = 1;
  localparam logic [LOG_BUFFER_LENGTH-1:0] PTR_ONE  = 1;
  localparam logic [LOG_N_CHANS-1:0]       ARB_ONE  = 1;

  logic [WDTH-1:0]              mem    [N_CHANS][BUFFER_LENGTH];
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr [N_CHANS];
  logic [LOG_BUFFER_LENGTH-1:0] rd_ptr [N_CHANS];
  logic [LOG_BUFFER_LENGTH:0]   count  [N_CHANS];
  logic [LOG_BUFFER_LENGTH:0]   cnt_nxt[N_CHANS];
  logic [N_CHANS-1:0]           err_pend;
  logic [LOG_N_CHANS-1:0]       arb_ptr;

  logic                   load;
  logic                   wr_ok;
  logic                   wr_ovf;
  logic [N_CHANS-1:0]     err_avail;
  logic [N_CHANS-1:0]     nonempty;
  logic                   do_err;
  logic                   do_pop;
  logic [LOG_N_CHANS-1:0] err_sel;
  logic [LOG_N_CHANS-1:0] pop_sel;
  logic [LOG_N_CHANS-1:0] rr_idx;
  logic                   err_any;
  logic                   pop_any;

  // Acceptance uses the count at the start of the cycle, so a full channel
  // refuses a write even if it is popped in the same cycle. A flushed channel
  // ignores the write entirely (no data, no error).
  assign load   = !out_nd || out_ready;
  assign wr_ok  = in_nd && !flush[in_chan] && (count[in_chan] != FULL_CNT);
  assign wr_ovf = in_nd && !flush[in_chan] && (count[in_chan] == FULL_CNT);

  always_comb begin
    err_avail = err_pend & ~flush;
    for (int c = 0; c < N_CHANS; c++) begin
      nonempty[c] = (count[c] != '0) && !flush[c];
    end

    // Lowest-index pending error: scan downwards so the last hit is the lowest.
    err_any = 1'b0;
    err_sel = '0;
    for (int c = N_CHANS - 1; c >= 0; c--) begin
      if (err_avail[c]) begin
        err_any = 1'b1;
        err_sel = LOG_N_CHANS'(c);
      end
    end

    // Round-robin from arb_ptr: scanning offsets downwards leaves the nearest
    // non-empty channel at or after arb_ptr as the winner.
    pop_any = 1'b0;
    pop_sel = '0;
    rr_idx  = '0;
    for (int i = N_CHANS - 1; i >= 0; i--) begin
      rr_idx = arb_ptr + LOG_N_CHANS'(i);
      if (nonempty[rr_idx]) begin
        pop_any = 1'b1;
        pop_sel = rr_idx;
      end
    end

    do_err = load && err_any;
    do_pop = load && !err_any && pop_any;

    for (int c = 0; c < N_CHANS; c++) begin
      cnt_nxt[c] = count[c];
      if (flush[c]) begin
        cnt_nxt[c] = '0;
      end else if ((wr_ok && in_chan == LOG_N_CHANS'(c)) && !(do_pop && pop_sel == LOG_N_CHANS'(c))) begin
        cnt_nxt[c] = count[c] + CNT_ONE;
      end else if (!(wr_ok && in_chan == LOG_N_CHANS'(c)) && (do_pop && pop_sel == LOG_N_CHANS'(c))) begin
        cnt_nxt[c] = count[c] - CNT_ONE;
      end
    end
  end

  // Storage is not reset: contents are meaningless once counts are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[in_chan][wr_ptr[in_chan]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CHANS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      err_pend <= '0;
      arb_ptr  <= '0;
      full     <= '0;
      afull    <= '0;
      out_data <= '0;
      out_chan <= '0;
      out_err  <= 1'b0;
      out_nd   <= 1'b0;
    end else begin
      for (int c = 0; c < N_CHANS; c++) begin
        count[c] <= cnt_nxt[c];
        full[c]  <= (cnt_nxt[c] == FULL_CNT);
        afull[c] <= (cnt_nxt[c] >= AF_CNT);
        if (flush[c]) begin
          wr_ptr[c]   <= '0;
          rd_ptr[c]   <= '0;
          err_pend[c] <= 1'b0;
        end else begin
          if (wr_ok && in_chan == LOG_N_CHANS'(c)) begin
            wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
          end
          if (do_pop && pop_sel == LOG_N_CHANS'(c)) begin
            rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
          end
          // A new overflow in the cycle its previous error is reported
          // starts a fresh pending error rather than being lost.
          if (wr_ovf && in_chan == LOG_N_CHANS'(c)) begin
            err_pend[c] <= 1'b1;
          end else if (do_err && err_sel == LOG_N_CHANS'(c)) begin
            err_pend[c] <= 1'b0;
          end
        end
      end

      if (do_err) begin
        out_data <= WRITEERRORCODE;
        out_chan <= err_sel;
        out_err  <= 1'b1;
        out_nd   <= 1'b1;
      end else if (do_pop) begin
        out_data <= mem[pop_sel][rd_ptr[pop_sel]];
        out_chan <= pop_sel;
        out_err  <= 1'b0;
        out_nd   <= 1'b1;
        arb_ptr  <= pop_sel + ARB_ONE;
      end else if (out_ready) begin
        out_nd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_mc.sv
module tb_buffer_mc;
  localparam int WDTH = 32;
  localparam int N    = 4;
  localparam int LN   = 2;
  localparam int BL   = 16;
  localparam int AF   = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [WDTH-1:0] in_data = '0;
  logic [LN-1:0]   in_chan = '0;
  logic            in_nd = 1'b0;
  logic [N-1:0]    flush = '0;
  logic            out_ready = 1'b0;
  logic [WDTH-1:0] out_data;
  logic [LN-1:0]   out_chan;
  logic            out_err;
  logic            out_nd;
  logic [N-1:0]    full;
  logic [N-1:0]    afull;

  int checks = 0;
  int errors = 0;
  logic [WDTH-1:0] exp_q[N][$];

  buffer_mc dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_chan(in_chan), .in_nd(in_nd),
    .flush(flush), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_err(out_err), .out_nd(out_nd), .full(full), .afull(afull)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int c, input logic [WDTH-1:0] d);
    in_nd   = 1'b1;
    in_chan = LN'(c);
    in_data = d;
    step();
    in_nd   = 1'b0;
  endtask

  task automatic clear_model();
    for (int c = 0; c < N; c++) exp_q[c].delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL reset_out_nd got %b need 0", out_nd); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h need 0", out_data); end
    checks++; if (out_chan !== '0) begin errors++; $display("FAIL reset_out_chan got %0d need 0", out_chan); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b need 0", out_err); end
    checks++; if (full !== '0) begin errors++; $display("FAIL reset_full got %b need 0", full); end
    checks++; if (afull !== '0) begin errors++; $display("FAIL reset_afull got %b need 0", afull); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word(input string tag);
    out_ready = 1'b1;
    write_word(2, 32'hA5);
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL %s_early_nd got %b need 0", tag, out_nd); end
    step();
    checks++; if (out_nd !== 1'b1) begin errors++; $display("FAIL %s_nd got %b need 1", tag, out_nd); end
    checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL %s_data got %h need a5", tag, out_data); end
    checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL %s_chan got %0d need 2", tag, out_chan); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL %s_err got %b need 0", tag, out_err); end
    step();
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL %s_idle got %b need 0", tag, out_nd); end
  endtask

  task automatic test_fairness();
    int chs[3] = '{0, 1, 3};
    int rr, ec, t;
    logic [WDTH-1:0] d, e;
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        d = $urandom;
        exp_q[chs[k]].push_back(d);
        write_word(chs[k], d);
      end
    end
    out_ready = 1'b1;
    rr = 0;
    for (int j = 0; j < 9; j++) begin
      // The very first word is loaded while only channel 0 holds data.
      if (j == 0) ec = 0;
      else begin
        ec = -1;
        for (int i = 0; i < N; i++) begin
          t = (rr + i) % N;
          if (ec < 0 && exp_q[t].size() > 0) ec = t;
        end
      end
      rr = (ec + 1) % N;
      e = exp_q[ec].pop_front();
      checks++; if (out_nd !== 1'b1) begin errors++; $display("FAIL fair_nd[%0d] got %b need 1", j, out_nd); end
      checks++; if (out_chan !== LN'(ec)) begin errors++; $display("FAIL fair_chan[%0d] got %0d need %0d", j, out_chan, ec); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL fair_data[%0d] got %h need %h", j, out_data, e); end
      step();
    end
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL fair_end_nd got %b need 0", out_nd); end
  endtask

  task automatic test_overflow();
    logic [WDTH-1:0] h, d, e;
    logic err_exp;
    err_exp = 1'b0;
    out_ready = 1'b0;
    h = $urandom;
    write_word(0, h);
    for (int i = 1; i <= 17; i++) begin
      d = $urandom;
      if (exp_q[1].size() < BL) exp_q[1].push_back(d);
      else err_exp = 1'b1;
      write_word(1, d);
      checks++; if (afull[1] !== (exp_q[1].size() >= AF)) begin errors++; $display("FAIL ovf_afull[%0d] got %b need %b", i, afull[1], exp_q[1].size() >= AF); end
      checks++; if (full[1] !== (exp_q[1].size() == BL)) begin errors++; $display("FAIL ovf_full[%0d] got %b need %b", i, full[1], exp_q[1].size() == BL); end
    end
    out_ready = 1'b1;
    checks++; if (out_nd !== 1'b1 || out_chan !== 2'd0 || out_data !== h) begin errors++; $display("FAIL ovf_held got nd=%b ch=%0d d=%h need nd=1 ch=0 d=%h", out_nd, out_chan, out_data, h); end
    step();
    checks++; if (out_nd !== err_exp || out_err !== err_exp || out_chan !== 2'd1 || out_data !== {WDTH{1'b1}}) begin errors++; $display("FAIL ovf_errword got nd=%b err=%b ch=%0d d=%h need nd=%b err=%b ch=1 d=ffffffff", out_nd, out_err, out_chan, out_data, err_exp, err_exp); end
    step();
    for (int i = 0; i < BL; i++) begin
      e = exp_q[1].pop_front();
      checks++; if (out_nd !== 1'b1 || out_err !== 1'b0 || out_chan !== 2'd1 || out_data !== e) begin errors++; $display("FAIL ovf_data[%0d] got nd=%b err=%b ch=%0d d=%h need nd=1 err=0 ch=1 d=%h", i, out_nd, out_err, out_chan, out_data, e); end
      step();
    end
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL ovf_end_nd got %b need 0", out_nd); end
    checks++; if (full[1] !== 1'b0 || afull[1] !== 1'b0) begin errors++; $display("FAIL ovf_end_flags got full=%b afull=%b need 0 0", full[1], afull[1]); end
  endtask

  task automatic test_backpressure();
    int outstanding[N];
    int writes, pending, cyc, c;
    logic prev_hold;
    logic [WDTH-1:0] prev_data, d, e;
    logic [LN-1:0] prev_chan;
    for (int i = 0; i < N; i++) outstanding[i] = 0;
    writes = 0; pending = 0; cyc = 0;
    prev_hold = 1'b0; prev_data = '0; prev_chan = '0;
    while ((writes < 200 || pending > 0) && cyc < 5000) begin
      @(negedge clk);
      if (prev_hold) begin
        checks++; if (out_nd !== 1'b1 || out_data !== prev_data || out_chan !== prev_chan) begin errors++; $display("FAIL bp_hold cyc %0d got nd=%b ch=%0d d=%h need nd=1 ch=%0d d=%h", cyc, out_nd, out_chan, out_data, prev_chan, prev_data); end
      end
      if (out_nd === 1'b1 && out_ready === 1'b1) begin
        if (exp_q[out_chan].size() == 0) begin
          checks++; errors++; $display("FAIL bp_spurious cyc %0d got ch=%0d d=%h need none", cyc, out_chan, out_data);
        end else begin
          e = exp_q[out_chan].pop_front();
          checks++; if (out_data !== e || out_err !== 1'b0) begin errors++; $display("FAIL bp_data cyc %0d ch=%0d got d=%h err=%b need d=%h err=0", cyc, out_chan, out_data, out_err, e); end
          outstanding[out_chan]--;
          pending--;
        end
      end
      prev_hold = (out_nd === 1'b1) && (out_ready === 1'b0);
      prev_data = out_data;
      prev_chan = out_chan;
      @(posedge clk);
      #1;
      cyc++;
      in_nd = 1'b0;
      if (writes < 200 && $urandom_range(0, 3) != 0) begin
        c = $urandom_range(0, N - 1);
        // Stay below channel capacity so every write is expected back.
        if (outstanding[c] < BL) begin
          d = $urandom;
          in_nd = 1'b1; in_chan = LN'(c); in_data = d;
          exp_q[c].push_back(d);
          outstanding[c]++; pending++; writes++;
        end
      end
      out_ready = (writes < 200) ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    in_nd = 1'b0;
    out_ready = 1'b1;
    checks++; if (cyc >= 5000) begin errors++; $display("FAIL bp_timeout got pending=%0d need 0", pending); end
    step();
    step();
  endtask

  task automatic test_flush();
    logic [WDTH-1:0] h, d, e;
    out_ready = 1'b0;
    h = $urandom;
    write_word(3, h);
    for (int i = 0; i < 2; i++) begin d = $urandom; exp_q[2].push_back(d); write_word(2, d); end
    for (int i = 0; i < 5; i++) begin d = $urandom; exp_q[0].push_back(d); write_word(0, d); end
    flush = 4'b0001;
    write_word(0, $urandom);
    flush = '0;
    exp_q[0].delete();
    checks++; if (full[0] !== 1'b0 || afull[0] !== 1'b0) begin errors++; $display("FAIL flush_flags got full=%b afull=%b need 0 0", full[0], afull[0]); end
    out_ready = 1'b1;
    checks++; if (out_nd !== 1'b1 || out_chan !== 2'd3 || out_data !== h) begin errors++; $display("FAIL flush_held got nd=%b ch=%0d d=%h need nd=1 ch=3 d=%h", out_nd, out_chan, out_data, h); end
    step();
    for (int i = 0; i < 2; i++) begin
      e = exp_q[2].pop_front();
      checks++; if (out_nd !== 1'b1 || out_chan !== 2'd2 || out_data !== e) begin errors++; $display("FAIL flush_other[%0d] got nd=%b ch=%0d d=%h need nd=1 ch=2 d=%h", i, out_nd, out_chan, out_data, e); end
      step();
    end
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL flush_empty got nd=%b ch=%0d need nd=0", out_nd, out_chan); end
    d = $urandom;
    write_word(0, d);
    step();
    checks++; if (out_nd !== 1'b1 || out_chan !== 2'd0 || out_data !== d) begin errors++; $display("FAIL flush_reuse got nd=%b ch=%0d d=%h need nd=1 ch=0 d=%h", out_nd, out_chan, out_data, d); end
    step();
    checks++; if (out_nd !== 1'b0) begin errors++; $display("FAIL flush_reuse_end got %b need 0", out_nd); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) write_word(1, $urandom);
    // One word sits in the output register, twelve remain queued.
    checks++; if (afull[1] !== 1'b1 || out_nd !== 1'b1) begin errors++; $display("FAIL arst_pre got afull=%b nd=%b need 1 1", afull[1], out_nd); end
    in_nd = 1'b1; in_chan = 2'd1; in_data = $urandom;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_nd !== 1'b0 || out_data !== '0 || out_chan !== '0 || out_err !== 1'b0) begin errors++; $display("FAIL arst_out got nd=%b d=%h ch=%0d err=%b need all 0", out_nd, out_data, out_chan, out_err); end
    checks++; if (full !== '0 || afull !== '0) begin errors++; $display("FAIL arst_flags got full=%b afull=%b need 0 0", full, afull); end
    in_nd = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    test_single_word("arst_single");
  endtask

  initial begin
    test_reset();
    test_single_word("single");
    test_fairness();
    test_overflow();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
